// File: rtl/spi_master.sv
// SPI frame master: serialises a cmd+payload frame MSB first and collects a byte back for read-data frames.
// Latency: SS_n falls the cycle after start is accepted; done pulses FW+2 cycles later (FW+RD_LATENCY+ADDR_SIZE+2 for reads).
// Backpressure: start is honoured only while ready (IDLE) and is otherwise dropped; optional SPI_MASTER_SEQ_CHECK_EN adds seq_err.
module spi_master #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_SIZE+1:0] frame_in,
  output logic                 ready,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 done
`ifdef SPI_MASTER_SEQ_CHECK_EN
  ,
  output logic                 seq_err
`endif
);

  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW + RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_TURN,
    S_READ,
    S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_cmd;
  logic [FW-1:0]         r_frame;
  logic [ADDR_SIZE-1:0]  r_rx;
  logic [ADDR_SIZE-1:0]  w_rx_next;
  logic [ADDR_SIZE-1:0]  r_rd_data;
  logic                  r_ss_n;
  logic                  r_mosi;
  logic                  r_done;
  logic                  r_rd_valid;
  logic                  w_last_rd;
  logic                  w_busy_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SEL;
      S_SEL:   w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(FW - 1))
                 w_next = (r_cmd == 2'b11) ? S_TURN : S_GAP;
      S_TURN:  if (r_cnt == CW'(RD_LATENCY - 1)) w_next = S_READ;
      S_READ:  if (r_cnt == CW'(ADDR_SIZE - 1)) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign w_last_rd   = (r_state == S_READ) && (w_next == S_GAP);
  assign w_busy_next = (w_next == S_SEL) || (w_next == S_SHIFT) ||
                       (w_next == S_TURN) || (w_next == S_READ);
  assign w_rx_next   = ADDR_SIZE'({r_rx, MISO});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cmd      <= '0;
      r_frame    <= '0;
      r_rx       <= '0;
      r_rd_data  <= '0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);

      if (r_state == S_IDLE && start) begin
        r_cmd   <= frame_in[FW-1:FW-2];
        r_frame <= frame_in;
      end else if (w_next == S_SHIFT) begin
        r_frame <= {r_frame[FW-2:0], 1'b0};
      end

      if (r_state == S_READ) r_rx <= w_rx_next;
      if (w_last_rd) r_rd_data <= w_rx_next;

      r_mosi     <= (w_next == S_SHIFT) ? r_frame[FW-1] : 1'b0;
      r_ss_n     <= !w_busy_next;
      r_done     <= (w_next == S_GAP);
      r_rd_valid <= w_last_rd;
    end
  end

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic r_rd_addr_seen;
  logic r_seq_err;

  // A rd-data frame consumes the address armed by the most recent completed rd-addr frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr_seen <= 1'b0;
      r_seq_err      <= 1'b0;
    end else begin
      r_seq_err <= w_last_rd && !r_rd_addr_seen;
      if (w_last_rd)
        r_rd_addr_seen <= 1'b0;
      else if (r_state == S_SHIFT && w_next == S_GAP && r_cmd == 2'b10)
        r_rd_addr_seen <= 1'b1;
    end
  end

  assign seq_err = r_seq_err;
`endif

  assign ready    = (r_state == S_IDLE);
  assign SS_n     = r_ss_n;
  assign MOSI     = r_mosi;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign done     = r_done;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (ADDR_SIZE=8, RD_LATENCY=2); cycle c is the period following edge c-1 of an accepted start.
module tb_spi_master;
  localparam int FW = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       MISO = 1'b0;
  logic [9:0] frame_in = '0;
  logic       ready, SS_n, MOSI, rd_valid, done;
  logic [7:0] rd_data;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic       seq_err;
`endif

  spi_master #(.ADDR_SIZE(8), .RD_LATENCY(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .frame_in (frame_in),
    .ready    (ready),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done)
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    .seq_err  (seq_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] c_ss, c_mosi, c_done, c_rdv, c_rdy, c_seq;
  logic [7:0]  c_rdd [0:31];

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mosi_bits(input logic [9:0] frame, input int base);
    logic [31:0] v = '0;
    for (int i = 0; i < FW; i++) v[base+i] = frame[FW-1-i];
    return v;
  endfunction

  // Called #1 after an edge with the DUT idle; start is sampled at the next edge (edge 0).
  task automatic run(input logic [9:0] frame, input logic [7:0] miso_byte, input int ncyc,
                     input int busy_cyc, input int hold_until);
    c_ss = '0; c_mosi = '0; c_done = '0; c_rdv = '0; c_rdy = '0; c_seq = '0;
    frame_in = frame;
    start    = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      start = (c <= hold_until) || (c == busy_cyc);
      if (c == busy_cyc) frame_in = 10'h1FF;
      MISO = (c >= 14 && c <= 21) ? miso_byte[21-c] : 1'b0;
      c_ss[c]   = SS_n;
      c_mosi[c] = MOSI;
      c_done[c] = done;
      c_rdv[c]  = rd_valid;
      c_rdy[c]  = ready;
      c_rdd[c]  = rd_data;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      c_seq[c]  = seq_err;
`endif
      @(posedge clk); #1;
    end
    start = 1'b0;
    MISO  = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [9:0] frame);
    check({tag, "_ss"},   c_ss,   span(1, 14) & ~span(1, 11));
    check({tag, "_mosi"}, c_mosi, mosi_bits(frame, 2));
    check({tag, "_done"}, c_done, span(12, 12));
    check({tag, "_rdv"},  c_rdv,  32'h0);
    check({tag, "_rdy"},  c_rdy,  span(13, 14));
  endtask

  task automatic check_rd(input string tag, input logic [9:0] frame, input logic [7:0] prev,
                          input logic [7:0] byte_exp);
    check({tag, "_ss"},    c_ss,   span(1, 24) & ~span(1, 21));
    check({tag, "_mosi"},  c_mosi, mosi_bits(frame, 2));
    check({tag, "_done"},  c_done, span(22, 22));
    check({tag, "_rdv"},   c_rdv,  span(22, 22));
    check({tag, "_rdy"},   c_rdy,  span(23, 24));
    check({tag, "_rdd21"}, {24'h0, c_rdd[21]}, {24'h0, prev});
    check({tag, "_rdd22"}, {24'h0, c_rdd[22]}, {24'h0, byte_exp});
    check({tag, "_rdd24"}, {24'h0, c_rdd[24]}, {24'h0, byte_exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready},    32'h1);
    check("rst_ss",    {31'h0, SS_n},     32'h1);
    check("rst_mosi",  {31'h0, MOSI},     32'h0);
    check("rst_done",  {31'h0, done},     32'h0);
    check("rst_rdv",   {31'h0, rd_valid}, 32'h0);
    check("rst_rdd",   {24'h0, rd_data},  32'h0);
`ifdef SPI_MASTER_SEQ_CHECK_EN
    check("rst_seq",   {31'h0, seq_err},  32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run(10'b00_1010_1011, 8'h00, 14, 0, 0);
    check_wr("wr_addr", 10'b00_1010_1011);

    run(10'b11_0000_0000, 8'h5A, 24, 0, 0);
    check_rd("rd_data1", 10'b11_0000_0000, 8'h00, 8'h5A);
`ifdef SPI_MASTER_SEQ_CHECK_EN
    check("seq_no_addr", c_seq, span(22, 22));
`endif

    run(10'b01_1111_0000, 8'h00, 14, 5, 0);
    check_wr("busy_drop", 10'b01_1111_0000);
    check("busy_rdd_hold", {24'h0, c_rdd[14]}, 32'h5A);

    run(10'b10_0101_0101, 8'h00, 14, 0, 0);
    check_wr("rd_addr", 10'b10_0101_0101);
    check("rdaddr_rdd_hold", {24'h0, c_rdd[14]}, 32'h5A);

    run(10'b11_1100_0011, 8'hC3, 24, 0, 0);
    check_rd("rd_data2", 10'b11_1100_0011, 8'h5A, 8'hC3);
`ifdef SPI_MASTER_SEQ_CHECK_EN
    check("seq_after_addr", c_seq, 32'h0);
`endif

    run(10'b00_0110_0110, 8'h00, 28, 0, 13);
    check("b2b_ss",   c_ss,   span(1, 28) & ~span(1, 11) & ~span(14, 24));
    check("b2b_mosi", c_mosi, mosi_bits(10'b00_0110_0110, 2) | mosi_bits(10'b00_0110_0110, 15));
    check("b2b_done", c_done, span(12, 12) | span(25, 25));
    check("b2b_rdy",  c_rdy,  span(13, 13) | span(26, 28));

    frame_in = 10'b00_1010_1011;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("mid_pre_ss",   {31'h0, SS_n}, 32'h0);
    check("mid_pre_mosi", {31'h0, MOSI}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss",    {31'h0, SS_n},    32'h1);
    check("mid_rst_mosi",  {31'h0, MOSI},    32'h0);
    check("mid_rst_ready", {31'h0, ready},   32'h1);
    check("mid_rst_rdd",   {24'h0, rd_data}, 32'h0);
    acc = '0;
    repeat (3) begin
      @(posedge clk); #1;
      acc[0] = acc[0] | done | rd_valid;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      acc[0] = acc[0] | done | rd_valid;
      acc[1] = acc[1] | !SS_n | !ready;
    end
    check("mid_rst_nopulse", acc, 32'h0);

    run(10'b01_0011_1100, 8'h00, 14, 0, 0);
    check_wr("post_rst", 10'b01_0011_1100);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    run(10'b11_0000_0001, 8'h81, 24, 0, 0);
    check("seq_after_rst", c_seq, span(22, 22));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, the address/data byte width; frame width FW = ADDR_SIZE+2.
REQ-002 SHALL have parameter RD_LATENCY, default 2, legal range 1..7: idle cycles between last MOSI bit and first MISO bit of a read-data frame.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to send one frame.
REQ-006 SHALL have port frame_in, input, FW, command frame [FW-1:FW-2] = cmd (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [ADDR_SIZE-1:0] = payload.
REQ-007 SHALL have port ready, output, 1, high only in IDLE.
REQ-008 SHALL have port SS_n, output, 1, slave select, active-low.
REQ-009 SHALL have port MOSI, output, 1, serial data to slave.
REQ-010 SHALL have port MISO, input, 1, serial data from slave.
REQ-011 SHALL have port rd_data, output, ADDR_SIZE, last byte read.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle pulse when rd_data updates.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of every frame.

Function
REQ-014 SHALL implement states IDLE, SEL, SHIFT, TURN, READ, GAP; all outputs registered except ready (decoded from state).
REQ-015 IDLE: SS_n=1, MOSI=0; start=1 at a clock edge latches frame_in and enters SEL; start while not ready SHALL be ignored, not queued.
REQ-016 SEL: exactly 1 cycle, SS_n=0, MOSI=0; then SHIFT.
REQ-017 SHIFT: exactly FW cycles, SS_n=0, MOSI = latched frame MSB first (bit FW-1 in first SHIFT cycle).
REQ-018 After last SHIFT cycle: cmd=11 -> TURN; any other cmd -> GAP.
REQ-019 TURN: exactly RD_LATENCY cycles, SS_n=0, MOSI=0; then READ.
REQ-020 READ: exactly ADDR_SIZE cycles, SS_n=0, MOSI=0; MISO sampled each rising edge into shift register, MSB first.
REQ-021 GAP: exactly 1 cycle, SS_n=1, done=1; for read-data frames rd_data loaded with the assembled byte and rd_valid=1 in same cycle; then IDLE.
REQ-022 Latency, ADDR_SIZE=8: non-read frame accepted at edge 0 -> SS_n low cycles 1..11, done cycle 12, ready cycle 13; read-data frame (RD_LATENCY=2) -> SS_n low cycles 1..21, done/rd_valid cycle 22.
REQ-023 Back-to-back: start held high in IDLE SHALL launch next frame, giving minimum SS_n-high of 2 cycles (GAP+IDLE) between frames.
REQ-024 rd_data SHALL hold its value between read-data frames; non-read frames SHALL not alter it.
REQ-025 Bit and cycle counters SHALL clear on every state entry; no wrap beyond FW, RD_LATENCY, or ADDR_SIZE.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, SS_n=1, MOSI=0, rd_data=0, rd_valid=0, done=0, counters=0; ready=1 during and after reset.
REQ-027 Reset mid-frame SHALL abort the frame with no done/rd_valid pulse; first start after release begins a fresh frame.

Configuration
REQ-028 Macro SPI_MASTER_SEQ_CHECK_EN, when defined, SHALL add output seq_err (1 bit, reset 0) pulsing one cycle in GAP when a rd-data frame completes with no rd-addr frame completed since reset or since the previous rd-data frame; the frame is still sent normally.
REQ-029 Without SPI_MASTER_SEQ_CHECK_EN the port and tracking logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Write-addr: start with frame_in=10'b00_1010_1011 -> MOSI 0,0,1,0,1,0,1,0,1,1 in cycles 2..11, SS_n low cycles 1..11, done cycle 12, rd_valid never high.
REQ-031 Read-data: frame_in=10'b11_0000_0000, model drives MISO=0x5A MSB first from cycle 14 -> rd_data=0x5A with rd_valid=1 in cycle 22 only.
REQ-032 Busy drop: second start with frame_in=10'h1FF during SHIFT -> ignored, only first frame's bits appear, one done pulse.
REQ-033 Reset mid-SHIFT: rst_n low at cycle 6 -> SS_n=1 and MOSI=0 same cycle, no done, ready=1; next frame transmits correctly.
REQ-034 SPI_MASTER_SEQ_CHECK_EN defined: rd-data without prior rd-addr -> seq_err=1 at GAP; rd-addr then rd-data -> seq_err stays 0.
